// File: rtl/mdu_pkg.sv
// Shared encodings and latency defaults for the multiply/divide unit.
// The md_op encodings for madd/maddu/msub/msubu are decoded only when MDU_MADD_EN is defined.
package mdu_pkg;

  localparam int unsigned MD_OP_W   = 3;
  localparam int unsigned MDU_WIDTH = 32;
  localparam int unsigned MULT_LAT  = 5;
  localparam int unsigned DIV_LAT   = 10;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MADD  = 3'd4,
    MD_MADDU = 3'd5,
    MD_MSUB  = 3'd6,
    MD_MSUBU = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // How the latched 64-bit result is folded into {HI,LO} at commit.
  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } acc_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 2*WIDTH result for a multiply/divide op, plus the divide-by-zero flag.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic [MD_OP_W-1:0] i_md_op,
  input  logic [WIDTH-1:0]   i_src_a,
  input  logic [WIDTH-1:0]   i_src_b,
  output logic [2*WIDTH-1:0] o_res_c,
  output logic               o_div0_c
);

  logic [2*WIDTH-1:0] w_sa;
  logic [2*WIDTH-1:0] w_sb;
  logic [2*WIDTH-1:0] w_ua;
  logic [2*WIDTH-1:0] w_ub;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic               w_b_zero;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_b_safe;
  logic [WIDTH-1:0]   w_quot_s;
  logic [WIDTH-1:0]   w_rem_s;
  logic [WIDTH-1:0]   w_quot_u;
  logic [WIDTH-1:0]   w_rem_u;

  // Operands widened to 2*WIDTH so the truncated product is exact.
  assign w_sa     = {{WIDTH{i_src_a[WIDTH-1]}}, i_src_a};
  assign w_sb     = {{WIDTH{i_src_b[WIDTH-1]}}, i_src_b};
  assign w_ua     = {{WIDTH{1'b0}}, i_src_a};
  assign w_ub     = {{WIDTH{1'b0}}, i_src_b};
  assign w_prod_s = w_sa * w_sb;
  assign w_prod_u = w_ua * w_ub;

  // Divisor forced to 1 for /0 and INT_MIN/-1: gives quot=a, rem=0, which is the
  // required INT_MIN/-1 answer and keeps the divider away from undefined cases.
  assign w_b_zero = (i_src_b == '0);
  assign w_ovf    = (i_src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_src_b == '1);
  assign w_b_safe = (w_b_zero || w_ovf) ? WIDTH'(1) : i_src_b;
  assign w_quot_s = $signed(i_src_a) / $signed(w_b_safe);
  assign w_rem_s  = $signed(i_src_a) % $signed(w_b_safe);
  assign w_quot_u = i_src_a / w_b_safe;
  assign w_rem_u  = i_src_a % w_b_safe;

  always_comb begin
    o_res_c  = '0;
    o_div0_c = 1'b0;
    case (i_md_op)
      MD_MULT, MD_MADD, MD_MSUB:    o_res_c = w_prod_s;
      MD_MULTU, MD_MADDU, MD_MSUBU: o_res_c = w_prod_u;
      MD_DIV: begin
        o_res_c  = {w_rem_s, w_quot_s};
        o_div0_c = w_b_zero;
      end
      MD_DIVU: begin
        o_res_c  = {w_rem_u, w_quot_u};
        o_div0_c = w_b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: fixed-latency busy window, HI/LO commit, mthi/mtlo.
// Optional MDU_MADD_EN adds madd/maddu/msub/msubu accumulating into {HI,LO} at commit.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH       = MDU_WIDTH,
  parameter int unsigned MULT_CYCLES = MULT_LAT,
  parameter int unsigned DIV_CYCLES  = DIV_LAT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               mt_we,
  input  logic               mt_sel,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] r_res;
  logic               r_div0;
  acc_e               r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  state_e             w_state_n;
  logic [CNT_W-1:0]   w_cnt_n;
  logic               w_busy_n;
  logic [2*WIDTH-1:0] w_res_n;
  logic               w_div0_n;
  acc_e               w_acc_n;
  logic [WIDTH-1:0]   w_hi_n;
  logic [WIDTH-1:0]   w_lo_n;

  logic               w_valid;
  logic               w_is_div;
  acc_e               w_acc;
  logic [2*WIDTH-1:0] w_arith;
  logic               w_div0;
  logic [2*WIDTH-1:0] w_commit;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .i_md_op  (md_op),
    .i_src_a  (src_a),
    .i_src_b  (src_b),
    .o_res_c  (w_arith),
    .o_div0_c (w_div0)
  );

  // Op decode: which encodings start an operation and how they commit.
  always_comb begin
    w_valid  = 1'b0;
    w_is_div = 1'b0;
    w_acc    = ACC_NONE;
    case (md_op)
      MD_MULT, MD_MULTU: w_valid = 1'b1;
      MD_DIV, MD_DIVU: begin
        w_valid  = 1'b1;
        w_is_div = 1'b1;
      end
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU: begin
        w_valid = 1'b1;
        w_acc   = ACC_ADD;
      end
      MD_MSUB, MD_MSUBU: begin
        w_valid = 1'b1;
        w_acc   = ACC_SUB;
      end
`endif
      default: ;
    endcase
  end

  // Accumulate uses {HI,LO} as it stands at the commit edge.
  always_comb begin
    w_commit = r_res;
    case (r_acc)
      ACC_ADD: w_commit = {r_hi, r_lo} + r_res;
      ACC_SUB: w_commit = {r_hi, r_lo} - r_res;
      default: ;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_busy_n  = r_busy;
    w_res_n   = r_res;
    w_div0_n  = r_div0;
    w_acc_n   = r_acc;
    w_hi_n    = r_hi;
    w_lo_n    = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (start && w_valid) begin
          w_state_n = ST_RUN;
          w_busy_n  = 1'b1;
          w_cnt_n   = w_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          w_res_n   = w_arith;
          w_div0_n  = w_div0;
          w_acc_n   = w_acc;
        end else if (mt_we && !start) begin
          if (mt_sel) w_hi_n = src_a;
          else        w_lo_n = src_a;
        end
      end
      ST_RUN: begin
        if (r_cnt == '0) begin
          w_state_n = ST_IDLE;
          w_busy_n  = 1'b0;
          if (!r_div0) begin
            w_hi_n = w_commit[2*WIDTH-1:WIDTH];
            w_lo_n = w_commit[WIDTH-1:0];
          end
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_res   <= '0;
      r_div0  <= 1'b0;
      r_acc   <= ACC_NONE;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_busy  <= w_busy_n;
      r_res   <= w_res_n;
      r_div0  <= w_div0_n;
      r_acc   <= w_acc_n;
      r_hi    <= w_hi_n;
      r_lo    <= w_lo_n;
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

`ifndef SYNTHESIS
  // The D-stage hazard unit must never let these through.
  a_no_start_busy: assert property (@(posedge clk) disable iff (reset) !(start && r_busy));
  a_no_mt_busy:    assert property (@(posedge clk) disable iff (reset) !(mt_we && (r_busy || start)));
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed, table-driven bench for mdu_ctrl; expectations depend on MDU_MADD_EN.
module tb_mdu_ctrl;
  import mdu_pkg::*;

`ifdef MDU_MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mt_we;
  logic        mt_sel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests;
  int n_fail;

  mdu_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .mt_we  (mt_we),
    .mt_sel (mt_sel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vec [NVEC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] h, input logic [31:0] l);
    mt_we = 1'b1; mt_sel = 1'b1; src_a = h; tick();
    mt_sel = 1'b0; src_a = l; tick();
    mt_we = 1'b0; mt_sel = 1'b0;
  endtask

  // Pulse start for one edge, then count busy cycles (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    tick();
    start = 1'b0; src_a = '0; src_b = '0;
    cyc = 0;
    while (busy && cyc < 64) begin
      cyc++;
      tick();
    end
  endtask

  initial begin
    int cyc;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; start = 1'b0; md_op = '0; src_a = '0; src_b = '0;
    mt_we = 1'b0; mt_sel = 1'b0;

    //          op        a              b              pre_hi         pre_lo         exp_hi                          exp_lo                          cyc
    vec[0]  = '{MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'd0,         32'd0,         32'hFFFF_FFFF,                  32'hFFFF_FFEB,                  5};
    vec[1]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'd0,         32'd0,         32'hFFFF_FFFF,                  32'hFFFF_FFFD,                  10};
    vec[2]  = '{MD_DIVU,  32'hFFFF_FFF9, 32'd2,         32'd0,         32'd0,         32'd1,                          32'h7FFF_FFFC,                  10};
    vec[3]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd3,         32'd3,         32'd0,                          32'h8000_0000,                  10};
    vec[4]  = '{MD_DIV,   32'd100,       32'd0,         32'd5,         32'd9,         32'd5,                          32'd9,                          10};
    vec[5]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'd2,         32'd0,         32'd0,         32'd1,                          32'hFFFF_FFFE,                  5};
    vec[6]  = '{MD_DIVU,  32'd77,        32'd0,         32'h0000_AAAA, 32'h0000_5555, 32'h0000_AAAA,                  32'h0000_5555,                  10};
    vec[7]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'd0,         32'd0,         32'h4000_0000,                  32'd0,                          5};
    vec[8]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd0,         32'hFFFF_FFFE,                  32'd1,                          5};
    vec[9]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd0,         32'd0,         32'd1,                          32'hFFFF_FFFD,                  10};
    vec[10] = '{MD_MULT,  32'h0001_0000, 32'h0001_0000, 32'd0,         32'd0,         32'd1,                          32'd0,                          5};
    vec[11] = '{MD_MADD,  32'd1,         32'd1,         32'd0,         32'hFFFF_FFFF, MADD_ON ? 32'd1 : 32'd0,        MADD_ON ? 32'd0 : 32'hFFFF_FFFF, MADD_ON ? 5 : 0};
    vec[12] = '{MD_MSUB,  32'd1,         32'd1,         32'd0,         32'd0,         MADD_ON ? 32'hFFFF_FFFF : 32'd0, MADD_ON ? 32'hFFFF_FFFF : 32'd0, MADD_ON ? 5 : 0};
    vec[13] = '{MD_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd0,         MADD_ON ? 32'hFFFF_FFFE : 32'd0, MADD_ON ? 32'd1 : 32'd0,        MADD_ON ? 5 : 0};
    vec[14] = '{MD_MSUBU, 32'd2,         32'd3,         32'd0,         32'd10,        32'd0,                          MADD_ON ? 32'd4 : 32'd10,       MADD_ON ? 5 : 0};

    tick(); tick();
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    // mthi / mtlo in IDLE touch only the selected register
    mt_we = 1'b1; mt_sel = 1'b0; src_a = 32'h0000_0077; tick();
    mt_sel = 1'b1; src_a = 32'h0000_1234; tick();
    mt_we = 1'b0;
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_lo_kept", lo, 32'h0000_0077);

    for (int i = 0; i < NVEC; i++) begin
      preload(vec[i].pre_hi, vec[i].pre_lo);
      run_op(vec[i].op, vec[i].a, vec[i].b, cyc);
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vec[i].exp_cyc));
      chk($sformatf("v%0d_hi", i), hi, vec[i].exp_hi);
      chk($sformatf("v%0d_lo", i), lo, vec[i].exp_lo);
      chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
    end

    // Busy rises exactly one cycle after start; HI/LO hold their old value while busy
    preload(32'h0000_00AA, 32'h0000_00BB);
    start = 1'b1; md_op = MD_DIV; src_a = 32'd50; src_b = 32'd7;
    chk("pre_start_busy", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    chk("run_busy_t1", 32'(busy), 32'd1);
    chk("no_bypass_hi", hi, 32'h0000_00AA);
    tick();
    chk("no_bypass_lo", lo, 32'h0000_00BB);
    // Reset in cycle T+2 aborts the divide
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (12) tick();
    chk("abort_discard_lo", lo, 32'd0);

    // A new mult after the abort completes normally
    run_op(MD_MULT, 32'd3, 32'hFFFF_FFFC, cyc);
    chk("post_rst_cycles", 32'(cyc), 32'd5);
    chk("post_rst_hi", hi, 32'hFFFF_FFFF);
    chk("post_rst_lo", lo, 32'hFFFF_FFF4);

    // Back-to-back ops: second start on the cycle busy drops
    run_op(MD_MULTU, 32'd6, 32'd7, cyc);
    run_op(MD_DIVU, 32'd45, 32'd6, cyc);
    chk("b2b_cycles", 32'(cyc), 32'd10);
    chk("b2b_hi", hi, 32'd3);
    chk("b2b_lo", lo, 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
